// File: rtl/bit_serial_alu_seq.sv
// bit_serial_alu_seq: runs one 1-bit ALU slice LSB-first over WIDTH cycles.
// Supported ops: AND, OR, ADD/SUB and SLT, with binv and an initial carry-in.
// Optional abort input is enabled by defining BSALU_ABORT_EN.

// One-bit ALU slice (AND/OR/ADD/SUB/SLT with binv + less)
module bsalu_slice (
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic       binv,
  input  logic       less,
  input  logic [1:0] sel,
  output logic       res,
  output logic       cout,
  output logic       set
);
  logic bmux, g, p;

  // slice datapath: generate/propagate, sum and carry, result select
  always_comb begin
    bmux = binv ? ~b : b;
    g    = a & bmux;
    p    = a | bmux;
    set  = a ^ bmux ^ cin;
    cout = (a & bmux) | (a & cin) | (bmux & cin);
    case (sel)
      2'b00:   res = g;
      2'b01:   res = p;
      2'b10:   res = set;
      default: res = less;
    endcase
  end
endmodule

module bit_serial_alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
`ifdef BSALU_ABORT_EN
  ,
  input  logic             abort
`endif
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, res_sh_q, res_sh_d;
  logic [2:0]       op_q, op_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d, ovf_q, ovf_d;
  logic [WIDTH-1:0] fin;
  logic             s_res, s_cout, s_set, abort_w;

`ifdef BSALU_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  bsalu_slice u_slice (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .binv (op_q[2]),
    .less (1'b0),
    .sel  (op_q[1:0]),
    .res  (s_res),
    .cout (s_cout),
    .set  (s_set)
  );

  // next-state: accept, serial bit steps, and final result/flag capture on the MSB pass
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    op_d     = op_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    fin      = {s_res, res_sh_q[WIDTH-1:1]};
    // SLT: the MSB set bit is the raw sign of A-B, patched into bit 0
    if (op_q[1:0] == 2'b11) fin[0] = s_set;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          op_d     = op;
          carry_d  = op[2];
          cnt_d    = '0;
          res_sh_d = '0;
          busy_d   = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (abort_w) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          res_sh_d = {s_res, res_sh_q[WIDTH-1:1]};
          carry_d  = s_cout;
          a_sh_d   = a_sh_q >> 1;
          b_sh_d   = b_sh_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          // result registers load here so they are valid for the whole done cycle
          if (cnt_q == LAST) begin
            result_d = fin;
            zero_d   = (fin == '0);
            ovf_d    = (op_q[1:0] == 2'b10) ? (carry_q ^ s_cout) : 1'b0;
            done_d   = 1'b1;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      op_q     <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign zero     = zero_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_bit_serial_alu_seq.sv
// Bench for bit_serial_alu_seq at WIDTH=8: vector table, random ops, re-pulse, reset, abort.
module tb_bit_serial_alu_seq;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
    logic         ov;
  } exp_t;

  typedef struct packed {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         z;
    logic         ov;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, zero, overflow;
  logic [W-1:0] result;
`ifdef BSALU_ABORT_EN
  logic         abort = 1'b0;
`endif

  bit_serial_alu_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .zero     (zero),
    .overflow (overflow)
`ifdef BSALU_ABORT_EN
    ,
    .abort    (abort)
`endif
  );

  always #5 clk = ~clk;

  int           checks = 0, failures = 0;
  int           ndone = 0, nexp = 0;
  exp_t         sb[$];
  exp_t         mon_e;
  logic [W-1:0] hold_res = '0;
  vec_t         tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // reference: whole-word arithmetic on the selected operands
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb);
    exp_t         e;
    logic [W-1:0] bm, sum;
    bm  = o[2] ? ~xb : xb;
    sum = xa + bm + {{(W-1){1'b0}}, o[2]};
    e.ov = 1'b0;
    case (o[1:0])
      2'b00: e.res = xa & bm;
      2'b01: e.res = xa | bm;
      2'b10: begin
        e.res = sum;
        e.ov  = (xa[W-1] == bm[W-1]) && (sum[W-1] != xa[W-1]);
      end
      default: e.res = {{(W-1){1'b0}}, sum[W-1]};
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  // scoreboard: every done pops one expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        mon_e = sb.pop_front();
        ndone++;
        chk("result", 32'(result), 32'(mon_e.res));
        chk("zero", 32'(zero), 32'(mon_e.z));
        chk("overflow", 32'(overflow), 32'(mon_e.ov));
        hold_res = mon_e.res;
      end
    end
  end

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input exp_t e, input bit repulse);
    int cyc;
    bit seen;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_hold", 32'(result), 32'(hold_res));
    op = o; a = xa; b = xb; start = 1'b1;
    sb.push_back(e);
    nexp++;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    op = 3'($urandom_range(0, 7)); a = W'($urandom); b = W'($urandom);
    chk("busy_after_accept", 32'(busy), 32'd1);
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      start = (repulse && cyc >= 1 && cyc <= 4) ? 1'b1 : 1'b0;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=none required=done");
    end else begin
      chk("latency", 32'(cyc), 32'(W));
      chk("busy_in_done", 32'(busy), 32'd1);
    end
  endtask

  task automatic expect_quiet(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    tbl[0] = '{3'b010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    tbl[1] = '{3'b110, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{3'b111, 8'hFE, 8'h03, 8'h01, 1'b0, 1'b0};
    tbl[3] = '{3'b111, 8'h03, 8'hFE, 8'h00, 1'b1, 1'b0};
    tbl[4] = '{3'b000, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
    tbl[5] = '{3'b001, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0};
    tbl[6] = '{3'b010, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    tbl[7] = '{3'b110, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};

    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // directed vectors
    for (int i = 0; i < 8; i++)
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, '{tbl[i].res, tbl[i].z, tbl[i].ov}, 1'b0);

    // random vectors against the model
    for (int i = 0; i < 10; i++) begin
      logic [2:0]   ro;
      logic [W-1:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = W'($urandom);
      rb = W'($urandom);
      run_op(ro, ra, rb, model(ro, ra, rb), 1'b0);
    end

    // start re-pulsed during RUN: ignored
    run_op(3'b010, 8'h12, 8'h34, '{8'h46, 1'b0, 1'b0}, 1'b1);
    expect_quiet(12);
    chk("hold_after_repulse", 32'(result), 32'h46);

    // reset in the middle of RUN
    @(negedge clk);
    op = 3'b010; a = 8'h21; b = 8'h10; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_zero", 32'(zero), 32'd0);
    chk("midrst_overflow", 32'(overflow), 32'd0);
    hold_res = '0;
    @(negedge clk);
    rst_n = 1'b1;
    expect_quiet(12);
    run_op(3'b010, 8'h21, 8'h10, '{8'h31, 1'b0, 1'b0}, 1'b0);

`ifdef BSALU_ABORT_EN
    // abort during RUN: no done, previous result held
    @(negedge clk);
    op = 3'b000; a = 8'hFF; b = 8'h0F; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_hold", 32'(result), 32'(hold_res));
    expect_quiet(12);
    run_op(3'b001, 8'h0A, 8'h50, '{8'h5A, 1'b0, 1'b0}, 1'b0);
`endif

    expect_quiet(3);
    chk("done_count", 32'(ndone), 32'(nexp));
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
